// File: rtl/led_seq_pkg.sv
// Shared types for the RGB fade sequencer: FSM states, colour encoding and
// the colour-advance helper.
package led_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RISE,
        ST_HOLD,
        ST_FALL,
        ST_NEXT
    } state_t;

    typedef enum logic [1:0] {
        COL_RED   = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2
    } colour_t;

    localparam colour_t COL_LAST = COL_BLUE;

    function automatic colour_t next_colour(input colour_t c);
        return (c == COL_LAST) ? COL_RED : colour_t'(c + 2'd1);
    endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Free-running PWM counter, duty comparator and the three registered LED
// outputs; only the channel matching the current phase may light.
module led_pwm_core
    import led_seq_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  colour_t             phase,
    output logic [2:0]          leds
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Strict compare: full-scale duty still leaves one low cycle per period.
    assign pwm_on = (pwm_cnt < duty);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) leds[c] <= 1'b0;
            else        leds[c] <= pwm_on && (phase == 2'(c));
        end
    end

endmodule

// File: rtl/led_fade_sequencer.sv
// RGB fade sequencer: tick-driven RISE/HOLD/FALL/NEXT colour cycler over PWM.
// Define LED_FADE_EN for stepped fading; otherwise each fade is a single jump.
module led_fade_sequencer
    import led_seq_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 4,
    parameter int HOLD_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       enable,
    output logic       redled,
    output logic       greenled,
    output logic       blueled,
    output logic [1:0] phase
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PWM_BITS-1:0] FS = '1;

    // Without fading a step of 2^PWM_BITS saturates/empties duty in one tick.
`ifdef LED_FADE_EN
    localparam int STEP_EFF = (STEP > 2**PWM_BITS) ? 2**PWM_BITS : STEP;
`else
    localparam int STEP_EFF = 2**PWM_BITS;
`endif
    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(STEP_EFF);

    if (STEP < 1 || HOLD_TICKS < 1) begin : g_bad_param
        $error("led_fade_sequencer: STEP and HOLD_TICKS must be >= 1");
    end

    state_t              state, state_nxt;
    colour_t             phase_q, phase_nxt;
    logic [PWM_BITS-1:0] duty, duty_nxt;
    logic [HW-1:0]       hold_cnt, hold_nxt;
    logic [PWM_BITS:0]   rise_sum;
    logic [2:0]          leds;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            phase_q  <= COL_RED;
            duty     <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            phase_q  <= phase_nxt;
            duty     <= duty_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_q;
        duty_nxt  = duty;
        hold_nxt  = hold_cnt;
        rise_sum  = {1'b0, duty} + STEP_W;
        if (!enable) begin
            state_nxt = ST_IDLE;
            phase_nxt = COL_RED;
            duty_nxt  = '0;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    duty_nxt  = '0;
                    state_nxt = ST_RISE;
                end
                ST_RISE: if (tick) begin
                    if (rise_sum >= {1'b0, FS}) begin
                        duty_nxt  = FS;
                        hold_nxt  = '0;
                        state_nxt = ST_HOLD;
                    end else begin
                        duty_nxt = rise_sum[PWM_BITS-1:0];
                    end
                end
                ST_HOLD: if (tick) begin
                    hold_nxt = hold_cnt + 1'b1;
                    if (hold_cnt == HW'(HOLD_TICKS - 1)) state_nxt = ST_FALL;
                end
                ST_FALL: if (tick) begin
                    if ({1'b0, duty} <= STEP_W) begin
                        duty_nxt  = '0;
                        state_nxt = ST_NEXT;
                    end else begin
                        duty_nxt = duty - STEP_W[PWM_BITS-1:0];
                    end
                end
                // Single-cycle colour advance; any tick seen here is dropped.
                ST_NEXT: begin
                    phase_nxt = next_colour(phase_q);
                    state_nxt = ST_RISE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    led_pwm_core #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty),
        .phase (phase_q),
        .leds  (leds)
    );

    assign redled   = leds[0];
    assign greenled = leds[1];
    assign blueled  = leds[2];
    assign phase    = phase_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer: duty is recovered by counting LED
// high cycles over one full 256-cycle PWM period.
module tb_led_fade_sequencer;

    localparam int HOLD = 2;
`ifdef LED_FADE_EN
    localparam int RISE_N  = 4;
    localparam int FALL_N  = 4;
    localparam int RISE1   = 64;
    localparam int AB_N    = 2;
    localparam int AB_DUTY = 128;
`else
    localparam int RISE_N  = 1;
    localparam int FALL_N  = 1;
    localparam int RISE1   = 255;
    localparam int AB_N    = 1;
    localparam int AB_DUTY = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n, tick, enable;
    logic       redled, greenled, blueled;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ticks;
        int duty;
        int ph;
    } vec_t;
    vec_t vecs[$];

    led_fade_sequencer #(.PWM_BITS(8), .STEP(64), .HOLD_TICKS(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .enable   (enable),
        .redled   (redled),
        .greenled (greenled),
        .blueled  (blueled),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    // ch = -1 means every channel must stay dark.
    task automatic measure(input string name, input int ch, input int duty, input int ph);
        int cnt[3];
        cnt = '{0, 0, 0};
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) check({name, ".phase"}, int'(phase), ph);
            cnt[0] += int'(redled);
            cnt[1] += int'(greenled);
            cnt[2] += int'(blueled);
        end
        check({name, ".red"},   cnt[0], (ch == 0) ? duty : 0);
        check({name, ".green"}, cnt[1], (ch == 1) ? duty : 0);
        check({name, ".blue"},  cnt[2], (ch == 2) ? duty : 0);
    endtask

    initial begin
`ifdef LED_FADE_EN
        vecs.push_back('{1, 64, 0});  vecs.push_back('{1, 128, 0});
        vecs.push_back('{1, 192, 0}); vecs.push_back('{1, 255, 0});
        vecs.push_back('{1, 255, 0}); vecs.push_back('{1, 255, 0});
        vecs.push_back('{1, 191, 0}); vecs.push_back('{1, 127, 0});
        vecs.push_back('{1, 63, 0});  vecs.push_back('{1, 0, 1});
        vecs.push_back('{1, 64, 1});  vecs.push_back('{3, 255, 1});
        vecs.push_back('{2, 255, 1}); vecs.push_back('{3, 63, 1});
        vecs.push_back('{1, 0, 2});   vecs.push_back('{4, 255, 2});
        vecs.push_back('{2, 255, 2}); vecs.push_back('{3, 63, 2});
`else
        vecs.push_back('{1, 255, 0}); vecs.push_back('{1, 255, 0});
        vecs.push_back('{1, 255, 0}); vecs.push_back('{1, 0, 1});
        vecs.push_back('{1, 255, 1}); vecs.push_back('{2, 255, 1});
        vecs.push_back('{1, 0, 2});   vecs.push_back('{1, 255, 2});
        vecs.push_back('{2, 255, 2});
`endif
        rst_n = 1'b0; enable = 1'b0; tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.red", int'(redled), 0);
        check("rst.green", int'(greenled), 0);
        check("rst.blue", int'(blueled), 0);
        check("rst.phase", int'(phase), 0);
        rst_n = 1'b1;
        measure("idle", -1, 0, 0);
        enable = 1'b1;
        measure("en_no_tick", 0, 0, 0);

        foreach (vecs[i]) begin
            do_ticks(vecs[i].ticks);
            measure($sformatf("vec%0d", i), vecs[i].ph, vecs[i].duty, vecs[i].ph);
        end

        // Last FALL tick immediately followed by a tick during NEXT.
        @(negedge clk) tick = 1'b1;
        @(negedge clk);
        @(negedge clk) tick = 1'b0;
        measure("wrap", 0, 0, 0);
        do_ticks(1);
        measure("wrap_rise", 0, RISE1, 0);

        do_ticks(RISE_N - 1 + HOLD + FALL_N);
        do_ticks(AB_N);
        measure("pre_abort", 1, AB_DUTY, 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort.phase_1st_edge", int'(phase), 0);
        measure("abort", -1, 0, 0);

        enable = 1'b1;
        do_ticks(RISE_N + HOLD + FALL_N + 1);
        begin
            int guard = 0;
            while (!greenled && guard < 600) begin
                @(negedge clk);
                guard++;
            end
        end
        check("rst_mid.green_seen", int'(greenled), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid.red", int'(redled), 0);
        check("rst_mid.green", int'(greenled), 0);
        check("rst_mid.blue", int'(blueled), 0);
        check("rst_mid.phase", int'(phase), 0);
        @(negedge clk) rst_n = 1'b1;
        measure("post_rst", -1, 0, 0);
        do_ticks(1);
        measure("post_rst_tick", 0, RISE1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
